// File: rtl/rotl_seq_if.sv
// -----------------------------------------------------------------------------
// rotl_seq_if
//   Handshake bundle for the rotl_seq left rotator.
//   Input stream  : in_valid / in_ready / in_data / in_amt  (producer -> rotator)
//   Output stream : out_valid / out_ready / out_data        (rotator -> consumer)
//   Modports
//     slave  : the rotator side (accepts words, presents results)
//     master : the environment side (offers words, consumes results)
//   Parameters
//     WIDTH : data width, power of two, >= 2. SHW is derived from it.
// -----------------------------------------------------------------------------
interface rotl_seq_if #(
  parameter int WIDTH = 8
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rotl_seq.sv
// -----------------------------------------------------------------------------
// rotl_seq
//   Multi-cycle left rotator with valid/ready handshakes. Accepts one word and
//   a rotate amount, rotates the word left by that amount and holds the result
//   until the consumer takes it. Rotating left by k undoes a right rotate by k.
//
//   Ports
//     clk    : single clock, all state updates on posedge
//     rst_n  : synchronous active-low reset, sampled on posedge clk
//     bus    : rotl_seq_if.slave
//                in_valid/in_ready/in_data/in_amt  - input word handshake
//                out_valid/out_ready/out_data      - result handshake
//     busy   : high while a word is being rotated or its result is held
//
//   Parameters
//     WIDTH  : data width, must be a power of two and >= 2 (default 8)
//
//   Configuration macro
//     ROTL_FAST_EN : when defined, the rotation is done at the accept edge by a
//                    log2(WIDTH)-stage mux rotator and the ROT state is unused.
//                    When undefined, the word is rotated one bit per clock.
//
//   Latency (accept edge to first cycle with out_valid=1): amt+1 edges in the
//   iterative build, 1 edge in the fast build. in_ready returns only in the
//   cycle after the result handshake, so input and output never overlap.
// -----------------------------------------------------------------------------
module rotl_seq #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rotl_seq_if.slave    bus,
  output logic         busy
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_r, data_nx;

`ifdef ROTL_FAST_EN
  // Rotate left by amt using one mux stage per amount bit; stage s moves the
  // word by 2**s positions when amt[s] is set.
  function automatic logic [WIDTH-1:0] rotl_stages(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   amt
  );
    logic [WIDTH-1:0] v;
    v = d;
    for (int s = 0; s < SHW; s++) begin
      if (amt[s]) v = (v << (1 << s)) | (v >> (WIDTH - (1 << s)));
    end
    return v;
  endfunction
`else
  logic [SHW-1:0] cnt, cnt_nx;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every register samples the values
  // from before the edge, independent of statement order across blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
`ifndef ROTL_FAST_EN
      cnt    <= '0;
`endif
    end else begin
      state  <= state_nx;
      data_r <= data_nx;
`ifndef ROTL_FAST_EN
      cnt    <= cnt_nx;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    data_nx  = data_r;
`ifndef ROTL_FAST_EN
    cnt_nx   = cnt;
`endif

    unique case (state)
      IDLE: begin
        // in_ready is high throughout IDLE once out of reset; the reset
        // branch of the register overrides anything decided here.
        if (bus.in_valid) begin
`ifdef ROTL_FAST_EN
          data_nx  = rotl_stages(bus.in_data, bus.in_amt);
          state_nx = HOLD;
`else
          data_nx  = bus.in_data;
          cnt_nx   = bus.in_amt;
          state_nx = (bus.in_amt == '0) ? HOLD : ROT;
`endif
        end
      end

`ifndef ROTL_FAST_EN
      ROT: begin
        // One position per clock; cnt counts the positions still to go.
        data_nx = {data_r[WIDTH-2:0], data_r[WIDTH-1]};
        cnt_nx  = cnt - SHW'(1);
        if (cnt == SHW'(1)) state_nx = HOLD;
      end
`endif

      HOLD: begin
        if (bus.out_ready) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // in_ready is gated by rst_n so no word is taken while reset is asserted.
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = data_r;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_rotl_seq.sv
// -----------------------------------------------------------------------------
// tb_rotl_seq
//   Self-checking bench for rotl_seq (WIDTH=8). A behavioural model tracks
//   the transaction timeline (accept, latency countdown, hold, consume) and
//   computes results from the bit-index definition of a left rotate; a
//   compare process checks the DUT against it every cycle. Directed tests
//   pin literal results and latencies; a final sweep covers all data/amount
//   pairs with random back-pressure and checks rotr-then-rotl round trips.
//   Define ROTL_FAST_EN for both bench and RTL to exercise the fast build.
// -----------------------------------------------------------------------------
module tb_rotl_seq;
  localparam int W = 8;
`ifdef ROTL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  rotl_seq_if #(.WIDTH(W)) bus ();

  rotl_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rotates written from the bit-index definitions.
  function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] d, input logic [2:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[(i - int'(k) + W) % W];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_rotr(input logic [W-1:0] d, input logic [2:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[(i + int'(k)) % W];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: a transaction is outstanding from accept until consumed;
  // its result becomes visible after the spec latency.
  // ---------------------------------------------------------------------------
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_wait  = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_wait  <= 0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_wait <= 1) m_valid <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (bus.in_valid) begin
      m_data  <= ref_rotl(bus.in_data, bus.in_amt);
      m_busy  <= 1'b1;
      m_wait  <= FAST ? 0 : int'(bus.in_amt);
      m_valid <= FAST || (bus.in_amt == 3'd0);
    end
  end

  // Count result handshakes as seen on the DUT pins (pre-edge values).
  int hs_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
  end

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    check("cmp_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    check("cmp_busy", {31'd0, busy}, {31'd0, m_busy});
    check("cmp_in_ready", {31'd0, bus.in_ready}, {31'd0, (rst_n && !m_busy)});
    // During an iterative rotation out_data shows partial work; skip it then.
    if (!m_busy || m_valid) check("cmp_out_data", {24'd0, bus.out_data}, {24'd0, m_data});
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks. Inputs change on negedge; samples are taken #1 after posedge.
  // ---------------------------------------------------------------------------
  // Offer a word and return just after the accept edge.
  task automatic send(input logic [W-1:0] d, input logic [2:0] k, input logic ordy);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = k;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Count edges from accept until out_valid; returns at the following negedge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("wait_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  // Consume the held result, optionally with random back-pressure.
  task automatic consume(input logic [W-1:0] held, input bit rnd);
    logic r;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n > 30) r = 1'b1;
      bus.out_ready = r;
      @(posedge clk);
      #1;
      if (!r) check("hold_stable", {24'd0, bus.out_data}, {24'd0, held});
      n++;
    end while (!r);
  endtask

  task automatic xact(input logic [W-1:0] d, input logic [2:0] k,
                      input logic [W-1:0] exp, input string name, input bit rnd);
    int lat;
    logic [W-1:0] res;
    send(d, k, 1'b0);
    wait_valid(lat);
    res = bus.out_data;
    check({name, "_data"}, {24'd0, res}, {24'd0, exp});
    check({name, "_latency"}, lat, FAST ? 32'd1 : 32'(int'(k) + 1));
    consume(res, rnd);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int hs0;
    int ov;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    // Reference pins.
    check("pin_rotl_81_1", {24'd0, ref_rotl(8'h81, 3'd1)}, 32'h03);
    check("pin_rotl_a5_4", {24'd0, ref_rotl(8'hA5, 3'd4)}, 32'h5A);
    check("pin_rotl_96_7", {24'd0, ref_rotl(8'h96, 3'd7)}, 32'h4B);
    check("pin_rotr_96_1", {24'd0, ref_rotr(8'h96, 3'd1)}, 32'h4B);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_high", {31'd0, bus.in_ready}, 32'd1);

    // Basic rotations with literal results.
    xact(8'b1000_0001, 3'd1, 8'b0000_0011, "t1_81_1", 1'b0);
    xact(8'hA5, 3'd4, 8'h5A, "t2_a5_4", 1'b0);
    xact(8'h96, 3'd7, 8'h4B, "t2_96_7", 1'b0);

    // amt=0 with out_ready already high: busy for exactly one cycle.
    send(8'h3C, 3'd0, 1'b1);
    check("t3_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t3_data", {24'd0, bus.out_data}, 32'h3C);
    check("t3_busy_on", {31'd0, busy}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t3_busy_off", {31'd0, busy}, 32'd0);
    check("t3_valid_off", {31'd0, bus.out_valid}, 32'd0);
    check("t3_data_kept", {24'd0, bus.out_data}, 32'h3C);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Back-pressure: result held for 5 cycles, input pulses ignored.
    send(8'hC3, 3'd3, 1'b0);
    wait_valid(lat);
    check("t4_latency", lat, FAST ? 32'd1 : 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid  = (i % 2 == 0);
      bus.in_data   = 8'hFF;
      bus.in_amt    = 'x;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("t4_hold_data", {24'd0, bus.out_data}, 32'h1E);
      check("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t4_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_amt    = '0;
    hs0           = hs_cnt;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_one_handshake", hs_cnt - hs0, 32'd1);
    check("t4_idle_after", {31'd0, busy}, 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during rotation: word dropped, no result appears.
    send(8'h01, 3'd6, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_out_data", {24'd0, bus.out_data}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
    ov = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ov++;
    end
    check("t5_no_stale", ov, 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Sweep: every word and amount, fed as rotr(d,k); rotl(k) must give d back.
    for (int d = 0; d < 256; d++) begin
      for (int k = 0; k < W; k++) begin
        xact(ref_rotr(8'(d), 3'(k)), 3'(k), 8'(d), "t6_roundtrip", 1'b1);
      end
    end

    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
